// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl
// Description : Multi-cycle IF/ID/EX/MEM/WB control FSM for an RV32I subset.
// Revision    : 1.0
// ============================================================================
module mc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        zero,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel_d,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        alu_src_b,
  output logic [3:0]  alu_op,
  output logic        ill_inst,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd7
  } state_t;

  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;

  state_t      state_q, state_d;
  logic [31:0] instret_q, instret_d;

  logic [6:0] w_opc;
  logic [2:0] w_funct3;
  logic       w_is_lui, w_is_opimm, w_is_op, w_is_br, w_is_jal, w_is_jalr, w_is_lw, w_is_sw;
  logic       w_legal, w_taken;
  logic       unused_inst_bits;

  assign w_opc      = inst[6:0];
  assign w_funct3   = inst[14:12];
  assign w_is_lui   = (w_opc == c_OPC_LUI);
  assign w_is_opimm = (w_opc == c_OPC_OPIMM);
  assign w_is_op    = (w_opc == c_OPC_OP);
  assign w_is_br    = (w_opc == c_OPC_BRANCH) && (w_funct3[2:1] == 2'b00);
  assign w_is_jal   = (w_opc == c_OPC_JAL);
  assign w_is_jalr  = (w_opc == c_OPC_JALR);
  assign w_is_lw    = (w_opc == c_OPC_LOAD)  && (w_funct3 == 3'b010);
  assign w_is_sw    = (w_opc == c_OPC_STORE) && (w_funct3 == 3'b010);
  assign w_legal    = w_is_lui | w_is_opimm | w_is_op | w_is_br |
                      w_is_jal | w_is_jalr | w_is_lw | w_is_sw;
  // funct3[0] distinguishes BNE from BEQ, so it simply inverts the zero test.
  assign w_taken    = zero ^ w_funct3[0];

  assign unused_inst_bits = ^{inst[31], inst[29:15], inst[11:7]};

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_sel_d = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'b00;
    rf_we     = 1'b0;
    wb_sel    = 2'b00;
    alu_src_b = 1'b0;
    alu_op    = 4'b0000;
    ill_inst  = 1'b0;

    case (state_q)
      S_IF: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we   = 1'b1;
          state_d = S_ID;
        end
      end
      S_ID: begin
        state_d = w_legal ? S_EX : S_TRAP;
      end
      S_EX: begin
        alu_src_b = ~(w_is_op | w_is_br);
        if (w_is_op)
          alu_op = {inst[30], w_funct3};
        else if (w_is_opimm)
          alu_op = {inst[30] & (w_funct3 == 3'b101), w_funct3};
        else if (w_is_br)
          alu_op = 4'b1000;

        if (w_is_br) begin
          pc_we   = 1'b1;
          pc_sel  = w_taken ? 2'b01 : 2'b00;
          state_d = S_IF;
        end else if (w_is_lw | w_is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_sel_d = 1'b1;
        mem_we    = w_is_sw;
        alu_src_b = 1'b1;
        if (mem_ack) begin
          if (w_is_sw) begin
            pc_we   = 1'b1;
            state_d = S_IF;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = S_IF;
        if (w_is_lw) begin
          wb_sel = 2'b01;
        end else if (w_is_lui) begin
          wb_sel = 2'b11;
        end else if (w_is_jal) begin
          wb_sel = 2'b10;
          pc_sel = 2'b01;
        end else if (w_is_jalr) begin
          wb_sel    = 2'b10;
          pc_sel    = 2'b10;
          alu_src_b = 1'b1;
        end
      end
      S_TRAP: begin
        ill_inst = 1'b1;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase

    // Reset masks every strobe so an in-flight request is simply dropped.
    if (rst) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_sel_d = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = 2'b00;
      rf_we     = 1'b0;
      wb_sel    = 2'b00;
      alu_src_b = 1'b0;
      alu_op    = 4'b0000;
      ill_inst  = 1'b0;
    end

    instret_d = instret_q + {31'd0, pc_we};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IF;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign state   = rst ? 3'd0 : state_q;
  assign instret = rst ? 32'd0 : instret_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_ctrl
// Description : Directed self-checking bench for the mc_ctrl sequencer.
// Revision    : 1.0
// ============================================================================
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        zero;
  logic        mem_ack;
  logic        mem_req, mem_we, mem_sel_d, ir_we, pc_we, rf_we, alu_src_b, ill_inst;
  logic [1:0]  pc_sel, wb_sel;
  logic [3:0]  alu_op;
  logic [2:0]  state;
  logic [31:0] instret;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  mc_ctrl u_dut (
    .clk       (clk),
    .rst       (rst),
    .inst      (inst),
    .zero      (zero),
    .mem_ack   (mem_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_sel_d (mem_sel_d),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .rf_we     (rf_we),
    .wb_sel    (wb_sel),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .ill_inst  (ill_inst),
    .state     (state),
    .instret   (instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Fetch with zero-wait ack, then pass through ID; returns at the start of EX.
  task automatic fetch(input logic [31:0] word, input string tag);
    inst    = word;
    mem_ack = 1'b1;
    #1;
    chk({tag, " if ir_we"}, {31'd0, ir_we}, 32'd1);
    chk({tag, " if state"}, {29'd0, state}, 32'd0);
    tick();
    mem_ack = 1'b0;
    #1;
    chk({tag, " id state"}, {29'd0, state}, 32'd1);
    tick();
  endtask

  initial begin
    rst = 1'b1; inst = 32'd0; zero = 1'b0; mem_ack = 1'b0;
    #1;
    chk("rst mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst state", {29'd0, state}, 32'd0);
    tick();
    tick();
    chk("rst instret", instret, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("idle state", {29'd0, state}, 32'd0);
      chk("idle mem_req", {31'd0, mem_req}, 32'd1);
      chk("idle ir_we", {31'd0, ir_we}, 32'd0);
      chk("idle instret", instret, 32'd0);
      tick();
    end

    // addi x1,x0,5
    fetch(32'h0050_0093, "addi");
    #1;
    chk("addi ex state", {29'd0, state}, 32'd2);
    chk("addi ex src_b", {31'd0, alu_src_b}, 32'd1);
    chk("addi ex alu_op", {28'd0, alu_op}, 32'h0);
    chk("addi ex pc_we", {31'd0, pc_we}, 32'd0);
    tick(); #1;
    chk("addi wb state", {29'd0, state}, 32'd4);
    chk("addi wb rf_we", {31'd0, rf_we}, 32'd1);
    chk("addi wb wb_sel", {30'd0, wb_sel}, 32'd0);
    chk("addi wb pc_we", {31'd0, pc_we}, 32'd1);
    chk("addi wb pc_sel", {30'd0, pc_sel}, 32'd0);
    tick(); #1;
    chk("addi back in IF", {29'd0, state}, 32'd0);
    chk("addi instret", instret, 32'd1);

    // lw x2,4(x0) with three wait cycles
    fetch(32'h0040_2103, "lw");
    #1;
    chk("lw ex src_b", {31'd0, alu_src_b}, 32'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3);
      #1;
      chk("lw mem state", {29'd0, state}, 32'd3);
      chk("lw mem req", {31'd0, mem_req}, 32'd1);
      chk("lw mem sel_d", {31'd0, mem_sel_d}, 32'd1);
      chk("lw mem we", {31'd0, mem_we}, 32'd0);
      chk("lw mem pc_we", {31'd0, pc_we}, 32'd0);
      tick();
    end
    mem_ack = 1'b0;
    #1;
    chk("lw wb state", {29'd0, state}, 32'd4);
    chk("lw wb wb_sel", {30'd0, wb_sel}, 32'd1);
    chk("lw wb rf_we", {31'd0, rf_we}, 32'd1);
    chk("lw wb mem_req", {31'd0, mem_req}, 32'd0);
    tick(); #1;
    chk("lw instret", instret, 32'd2);

    // beq taken
    fetch(32'h0000_0463, "beq1");
    zero = 1'b1; #1;
    chk("beq taken pc_we", {31'd0, pc_we}, 32'd1);
    chk("beq taken pc_sel", {30'd0, pc_sel}, 32'd1);
    chk("beq alu_op", {28'd0, alu_op}, 32'h8);
    chk("beq src_b", {31'd0, alu_src_b}, 32'd0);
    chk("beq rf_we", {31'd0, rf_we}, 32'd0);
    tick(); zero = 1'b0; #1;
    chk("beq back in IF", {29'd0, state}, 32'd0);
    chk("beq instret", instret, 32'd3);

    // beq not taken
    fetch(32'h0000_0463, "beq0");
    zero = 1'b0; #1;
    chk("beq nt pc_we", {31'd0, pc_we}, 32'd1);
    chk("beq nt pc_sel", {30'd0, pc_sel}, 32'd0);
    tick(); #1;
    chk("beq nt instret", instret, 32'd4);

    // bne: not taken when zero=1, taken when zero=0
    fetch(32'h0000_1463, "bne");
    zero = 1'b1; #1;
    chk("bne nt pc_sel", {30'd0, pc_sel}, 32'd0);
    zero = 1'b0; #1;
    chk("bne taken pc_sel", {30'd0, pc_sel}, 32'd1);
    tick(); #1;
    chk("bne instret", instret, 32'd5);

    // jalr x1,0(x2)
    fetch(32'h0001_00e7, "jalr");
    #1;
    chk("jalr ex src_b", {31'd0, alu_src_b}, 32'd1);
    tick(); #1;
    chk("jalr wb rf_we", {31'd0, rf_we}, 32'd1);
    chk("jalr wb wb_sel", {30'd0, wb_sel}, 32'd2);
    chk("jalr wb pc_sel", {30'd0, pc_sel}, 32'd2);
    chk("jalr wb src_b", {31'd0, alu_src_b}, 32'd1);
    tick(); #1;
    chk("jalr instret", instret, 32'd6);

    // sub x0,x1,x2
    fetch(32'h4020_8033, "sub");
    #1;
    chk("sub ex alu_op", {28'd0, alu_op}, 32'h8);
    chk("sub ex src_b", {31'd0, alu_src_b}, 32'd0);
    tick(); #1;
    chk("sub wb wb_sel", {30'd0, wb_sel}, 32'd0);
    tick(); #1;
    chk("sub instret", instret, 32'd7);

    // sw x2,4(x0), zero-wait: ack retires and IF requests immediately
    fetch(32'h0020_2223, "sw");
    tick();
    mem_ack = 1'b1; #1;
    chk("sw mem we", {31'd0, mem_we}, 32'd1);
    chk("sw mem pc_we", {31'd0, pc_we}, 32'd1);
    chk("sw mem rf_we", {31'd0, rf_we}, 32'd0);
    tick(); mem_ack = 1'b0; #1;
    chk("sw then IF", {29'd0, state}, 32'd0);
    chk("sw then mem_req", {31'd0, mem_req}, 32'd1);
    chk("sw instret", instret, 32'd8);

    // jal x0,8
    fetch(32'h0080_006f, "jal");
    tick(); #1;
    chk("jal wb wb_sel", {30'd0, wb_sel}, 32'd2);
    chk("jal wb pc_sel", {30'd0, pc_sel}, 32'd1);
    tick();

    // lui x1,0x12345
    fetch(32'h1234_50b7, "lui");
    #1;
    chk("lui ex alu_op", {28'd0, alu_op}, 32'h0);
    tick(); #1;
    chk("lui wb wb_sel", {30'd0, wb_sel}, 32'd3);
    tick();

    // srai x1,x1,1
    fetch(32'h4010_d093, "srai");
    #1;
    chk("srai ex alu_op", {28'd0, alu_op}, 32'hD);
    tick(); tick(); #1;
    chk("srai instret", instret, 32'd11);

    // Illegal encoding
    fetch(32'hFFFF_FFFF, "ill");
    for (int i = 0; i < 10; i++) begin
      mem_ack = i[0];
      #1;
      chk("trap state", {29'd0, state}, 32'd7);
      chk("trap ill_inst", {31'd0, ill_inst}, 32'd1);
      chk("trap mem_req", {31'd0, mem_req}, 32'd0);
      chk("trap instret", instret, 32'd11);
      tick();
    end
    mem_ack = 1'b0;
    rst = 1'b1; #1;
    chk("trap rst state", {29'd0, state}, 32'd0);
    chk("trap rst ill_inst", {31'd0, ill_inst}, 32'd0);
    tick();
    rst = 1'b0; #1;
    chk("post-trap state", {29'd0, state}, 32'd0);
    chk("post-trap mem_req", {31'd0, mem_req}, 32'd1);
    chk("post-trap instret", instret, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control FSM for the RV32I core subset (LUI, OP-IMM, OP, BRANCH BEQ/BNE, JAL, JALR, LW, SW). It sequences one shared memory port, the instruction register, the PC, the register file and the ALU across IF/ID/EX/MEM/WB states. Immediate generation stays in the existing combinational immediate unit, which is fed from the IR. The block also keeps a retired-instruction counter and traps on illegal encodings.

## Interface
- No parameters.
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- inst  in  32  IR contents; stable from ID until the next IF ack.
- zero  in  1  ALU zero flag (rs1−rs2), valid in EX.
- mem_ack  in  1  one-cycle completion pulse for the current request; ignored when mem_req=0.
- mem_req  out  1  memory request; held until the ack cycle, inclusive.
- mem_we  out  1  1 = store, 0 = read.
- mem_sel_d  out  1  address source: 0 = PC (fetch), 1 = ALU result (data).
- ir_we  out  1  load IR from read data.
- pc_we  out  1  PC update strobe; asserted once per retired instruction.
- pc_sel  out  2  00 PC+4, 01 PC+imm32, 10 (rs1+imm32)&~1.
- rf_we  out  1  register-file write enable.
- wb_sel  out  2  00 ALU, 01 load data, 10 PC+4, 11 imm32.
- alu_src_b  out  1  0 = rs2, 1 = imm32.
- alu_op  out  4  {f7b5, funct3}; 0000 = ADD, 1000 = SUB.
- ill_inst  out  1  high while in TRAP.
- state  out  3  IF=0, ID=1, EX=2, MEM=3, WB=4, TRAP=7.
- instret  out  32  retired-instruction count.

## Operation
- The state is a register. All other outputs are combinational from state, inst, zero and mem_ack. Any output not listed for a state is 0.
- IF
  - mem_req=1, mem_sel_d=0, mem_we=0.
  - On mem_ack: ir_we=1, next state ID. Otherwise stay in IF.
- ID
  - Decode inst[6:0].
  - Legal encodings: opcodes 0110111, 0010011, 0110011, 1100011 with funct3 000/001, 1101111, 1100111, 0000011 with funct3 010, 0100011 with funct3 010.
  - Legal → EX. Anything else → TRAP.
- EX
  - alu_src_b=0 for OP and BRANCH, otherwise 1.
  - alu_op by class:
    - OP: {inst[30], funct3}.
    - OP-IMM: {inst[30] only when funct3=101, else 0, funct3}.
    - BRANCH: 1000.
    - All other classes: 0000.
  - BRANCH retires here: pc_we=1, pc_sel=01 when taken, else 00. Taken means BEQ&zero or BNE&!zero. Next state IF.
  - LW/SW → MEM. All other classes → WB.
- MEM
  - mem_req=1, mem_sel_d=1, mem_we=1 for SW. alu_op=0000 and alu_src_b=1 are held.
  - On ack, SW retires: pc_we=1, pc_sel=00, next state IF.
  - On ack, LW → WB.
  - No ack: stay in MEM.
- WB: rf_we=1, pc_we=1, then IF. By class:
  - OP/OP-IMM: wb_sel=00, pc_sel=00.
  - LW: wb_sel=01, pc_sel=00.
  - LUI: wb_sel=11, pc_sel=00.
  - JAL: wb_sel=10, pc_sel=01.
  - JALR: wb_sel=10, pc_sel=10; alu_op=0000 and alu_src_b=1 are held.
- TRAP: ill_inst=1; all enables and mem_req are 0. Only rst leaves TRAP.
- instret increments on every cycle with pc_we=1 and wraps 0xFFFFFFFF→0.

## Timing
- While rst=1: all outputs forced to 0 (state reads 0, instret 0). After the edge: state=IF, instret=0.
- The first cycle after reset release is IF with mem_req=1.
- Reset mid-operation, including mid-request: the request is abandoned, with no pc_we/rf_we. The memory side must tolerate a dropped request.
- Latency with zero-wait memory (ack in the first request cycle):
  - BRANCH: 3 cycles.
  - SW: 4 cycles.
  - ALU/LUI/JAL/JALR: 4 cycles.
  - LW: 5 cycles.
  - Each wait cycle adds 1.
- mem_req falls the cycle after the ack cycle. No back-to-back request without an intervening state change, except SW-ack→IF, which is legal and asserts mem_req immediately.
- mem_ack during ID/EX/WB/TRAP has no effect.
- pc_we and rf_we are never high in the same cycle as ir_we.

## Test plan
- Reset: rst high 2 cycles, then low with mem_ack=0 for 5 cycles → state=0, mem_req=1, ir_we=0, instret=0 throughout.
- addi x1,x0,5 (0x00500093), fetch ack in first cycle:
  - IF ir_we=1.
  - EX alu_src_b=1, alu_op=0000.
  - WB rf_we=1, wb_sel=00, pc_we=1, pc_sel=00.
  - instret=1; back in IF at cycle 5.
- lw x2,4(x0) (0x00402103), data ack after 3 waits:
  - MEM holds mem_req=1, mem_sel_d=1, mem_we=0 for 4 cycles.
  - Then WB wb_sel=01, rf_we=1.
- Branches in EX:
  - beq 0x00000463 with zero=1 → pc_we=1, pc_sel=01, alu_op=1000, rf_we=0.
  - Same with zero=0 → pc_sel=00.
  - bne 0x00001463 with zero=0 → pc_sel=01.
- Jump and SUB:
  - jalr x1,0(x2) (0x000100e7) → WB rf_we=1, wb_sel=10, pc_sel=10.
  - sub 0x40208033 → EX alu_op=1000, alu_src_b=0.
- Trap and reset-out: 0xFFFFFFFF fetched → ID then TRAP (state=7), ill_inst=1, mem_req=0 for 10 cycles, instret unchanged. Then rst pulse → IF, instret=0.
